reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/rst_seq_pkg.sv | 25 ++
 rtl/reset_sequencer_if.sv | 42 ++++
 rtl/sync_ff.sv | 40 ++++
 rtl/reset_sequencer.sv | 129 ++++++++++++
 tb/tb_reset_sequencer.sv | 122 ++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq_pkg
//  Purpose  : Shared types and default parameter values for reset_sequencer.
//             Holds the sequencer state enum, the lock-loss counter width and
//             the default timing parameters.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rst_seq_pkg;

  localparam int C_DEF_STABLE_CYCLES  = 1024;
  localparam int C_DEF_STAGGER_CYCLES = 16;
  localparam int C_DEF_SYNC_STAGES    = 2;
  localparam int C_LLC_W              = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    PERIPH_UP = 2'd2,
    RUN       = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer_if
//  Purpose  : Groups the PLL lock input and the reset/status outputs of the
//             reset sequencer.
//  Signals  : pll_locked    - PLL lock indication (asynchronous to clk)
//             periph_rst    - active-high bus/peripheral reset
//             core_rst      - active-high core reset
//             ready         - both resets released
//             lock_loss_cnt - saturating lock-loss event count
//  Modports : slave  - the sequencer (consumes pll_locked, drives resets)
//             master - the surrounding system (drives pll_locked)
//  Revision : 1.0  initial release
// ============================================================================
interface reset_sequencer_if
  import rst_seq_pkg::*;
();

  logic               pll_locked;
  logic               periph_rst;
  logic               core_rst;
  logic               ready;
  logic [C_LLC_W-1:0] lock_loss_cnt;

  modport master (
    output pll_locked,
    input  periph_rst,
    input  core_rst,
    input  ready,
    input  lock_loss_cnt
  );

  modport slave (
    input  pll_locked,
    output periph_rst,
    output core_rst,
    output ready,
    output lock_loss_cnt
  );

endinterface
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ff
//  Purpose  : Multi-flop synchroniser for a single asynchronous bit.
//  Params   : STAGES - number of flops in the chain (>= 1)
//  Ports    : clk - destination clock
//             rst - synchronous active-high reset, clears the chain
//             i_d - asynchronous input bit
//             o_q - synchronised output (last flop of the chain)
//  Revision : 1.0  initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q
);

  logic [STAGES-1:0] r_chain;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) r_chain <= '0;
        else     r_chain <= i_d;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) r_chain <= '0;
        else     r_chain <= {r_chain[STAGES-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Releases peripheral reset after the PLL has been locked for
//             STABLE_CYCLES cycles, then core reset STAGGER_CYCLES later.
//             Any lock loss re-asserts both resets and is counted.
//  Params   : STABLE_CYCLES  - locked cycles required before any release
//             STAGGER_CYCLES - cycles between peripheral and core release
//             SYNC_STAGES    - depth of the pll_locked synchroniser
//  Ports    : clk - PLL output clock (sole clock)
//             rst - synchronous active-high reset
//             bus - reset_sequencer_if.slave (pll_locked in; periph_rst,
//                   core_rst, ready, lock_loss_cnt out, all registered)
//  Revision : 1.0  initial release
// ============================================================================
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STABLE_CYCLES  = C_DEF_STABLE_CYCLES,
  parameter int STAGGER_CYCLES = C_DEF_STAGGER_CYCLES,
  parameter int SYNC_STAGES    = C_DEF_SYNC_STAGES
) (
  input  wire logic         clk,
  input  wire logic         rst,
  reset_sequencer_if.slave  bus
);

  localparam int C_CNT_MAX = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
  localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
  localparam logic [C_CNT_W-1:0] C_STABLE_LAST  = C_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_STAGGER_LAST = C_CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [C_LLC_W-1:0] C_LLC_SAT      = '1;

  logic               w_locked_s;
  state_t             r_state, w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               w_lock_loss;
  logic               r_periph_rst, r_core_rst, r_ready;
  logic [C_LLC_W-1:0] r_llc, w_llc_nxt;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync_lock (
    .clk (clk),
    .rst (rst),
    .i_d (bus.pll_locked),
    .o_q (w_locked_s)
  );

  // Every non-WAIT_LOCK state is only entered or held with locked_s high, so
  // seeing locked_s low there is exactly a 1->0 transition of locked_s.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lock_loss = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = STABILIZE;
          w_cnt_nxt   = '0;
        end
      end
      STABILIZE: begin
        if (!w_locked_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_lock_loss = 1'b1;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_nxt = PERIPH_UP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PERIPH_UP: begin
        if (!w_locked_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_lock_loss = 1'b1;
        end else if (r_cnt == C_STAGGER_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_lock_loss = 1'b1;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase

    w_llc_nxt = (w_lock_loss && (r_llc != C_LLC_SAT)) ? r_llc + 8'd1 : r_llc;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WAIT_LOCK;
      r_cnt        <= '0;
      r_periph_rst <= 1'b1;
      r_core_rst   <= 1'b1;
      r_ready      <= 1'b0;
      r_llc        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_periph_rst <= !((w_state_nxt == PERIPH_UP) || (w_state_nxt == RUN));
      r_core_rst   <= (w_state_nxt != RUN);
      r_ready      <= (w_state_nxt == RUN);
      r_llc        <= w_llc_nxt;
    end
  end

  assign bus.periph_rst    = r_periph_rst;
  assign bus.core_rst      = r_core_rst;
  assign bus.ready         = r_ready;
  assign bus.lock_loss_cnt = r_llc;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Purpose  : Self-checking bench for reset_sequencer (STABLE_CYCLES=8,
//             STAGGER_CYCLES=4, SYNC_STAGES=2). Expected outputs for each
//             edge are queued when the stimulus is applied and compared once
//             the edge has happened.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

  localparam int C_STABLE  = 8;
  localparam int C_STAGGER = 4;
  localparam int C_SYNC    = 2;
  // Edge (counted from the last edge before pll_locked is driven high, or
  // from the last edge that sampled rst high) at which each reset falls.
  localparam int C_T_PERIPH = C_SYNC + 1 + C_STABLE;
  localparam int C_T_CORE   = C_T_PERIPH + C_STAGGER;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic clk   = 1'b0;
  logic rst   = 1'b1;

  reset_sequencer_if u_if ();

  reset_sequencer #(
    .STABLE_CYCLES  (C_STABLE),
    .STAGGER_CYCLES (C_STAGGER),
    .SYNC_STAGES    (C_SYNC)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] pk(input bit p, input bit c, input bit r, input int n);
    logic [7:0] n8;
    n8 = n[7:0];
    return {p, c, r, n8};
  endfunction

  function automatic logic [10:0] rel(input int k, input int llc);
    return pk(k < C_T_PERIPH, k < C_T_CORE, k >= C_T_CORE, llc);
  endfunction

  task automatic check_val(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: periph/core/ready/cnt observed %b/%b/%b/%0d, expected %b/%b/%b/%0d",
               tag, obs[10], obs[9], obs[8], obs[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, take the edge,
  // then pop the expectation and compare against the outputs.
  task automatic step(input bit r, input bit pl, input logic [10:0] e, input string tag);
    exp_t x;
    rst            = r;
    u_if.pll_locked = pl;
    sb_q.push_back('{tag, e});
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_val(x.tag, {u_if.periph_rst, u_if.core_rst, u_if.ready, u_if.lock_loss_cnt}, x.v);
  endtask

  initial begin
    u_if.pll_locked = 1'b0;

    // Reset then a long unlocked period: nothing may be released.
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, pk(1, 1, 0, 0), $sformatf("rst_%0d", i));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, pk(1, 1, 0, 0), $sformatf("idle_%0d", i));

    // Clean lock: periph at edge 11, core/ready at edge 15.
    for (int k = 1; k <= 20; k++) step(1'b0, 1'b1, rel(k, 0), $sformatf("lock_%0d", k));

    // Lock loss from RUN: resets back at edge 3, one event counted.
    for (int k = 1; k <= 6; k++)
      step(1'b0, 1'b0, (k < 3) ? pk(0, 0, 1, 0) : pk(1, 1, 0, 1), $sformatf("drop_%0d", k));

    step(1'b1, 1'b0, pk(1, 1, 0, 0), "rst_clr1");

    // One-cycle glitch after 5 locked cycles: count restarts, event counted.
    for (int k = 1; k <= 21; k++)
      step(1'b0, (k != 6), pk(k < 17, k < 21, k >= 21, (k >= 8) ? 1 : 0), $sformatf("glitch_%0d", k));

    // rst from RUN with the PLL still locked: full restart, counter cleared.
    step(1'b1, 1'b1, pk(1, 1, 0, 0), "rst_run");
    for (int k = 1; k <= 12; k++) step(1'b0, 1'b1, rel(k, 0), $sformatf("rel_a_%0d", k));

    // rst while in PERIPH_UP: immediate reassert, release timing repeats.
    step(1'b1, 1'b1, pk(1, 1, 0, 0), "rst_pu");
    for (int k = 1; k <= 20; k++) step(1'b0, 1'b1, rel(k, 0), $sformatf("rel_b_%0d", k));

    // Toggle pll_locked every cycle: one lock-loss event per two cycles,
    // counter must saturate at 255.
    for (int j = 1; j <= 600; j++) begin
      int n;
      n = (j - 1) / 2;
      if (n > 255) n = 255;
      step(1'b0, (j % 2) == 0, (j < 3) ? pk(0, 0, 1, n) : pk(1, 1, 0, n), $sformatf("storm_%0d", j));
    end
    for (int h = 1; h <= 4; h++) step(1'b0, 1'b0, pk(1, 1, 0, 255), $sformatf("sat_%0d", h));
    step(1'b1, 1'b0, pk(1, 1, 0, 0), "rst_clr2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
